serial_sub_unit: RTL and testbench
==================================

Name: serial_sub_unit

Overview:
Parametrised bit-serial N-bit subtractor that computes D = A - B - borrow_in, one bit per clock, LSB first, through a single full-subtractor bit cell. It uses a start/busy/done handshake and reports the final borrow and the signed overflow. It is the sequential, width-generic successor to the single-bit full subtractor and is intended as the arithmetic unit for small datapath labs where area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  synchronous active-low reset
start  input  1  request a subtraction; sampled only in IDLE
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
borrow_in  input  1  initial borrow; captured on the accepted start edge
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; result outputs are valid and newly updated
diff  output  WIDTH  result A - B - borrow_in, modulo 2^WIDTH
borrow_out  output  1  borrow out of the MSB; 1 when the unsigned A < B + borrow_in
overflow  output  1  signed overflow, equal to (borrow into MSB) XOR (borrow out of MSB)

Behaviour:
- Reset: one clock; reset is synchronous and active-low. rst_n low at a clk edge gives state=IDLE, busy=0, done=0, diff=0, borrow_out=0, overflow=0, and clears the bit counter and internal registers. Reset asserted mid-operation aborts the operation. No done pulse is produced and the outputs go to their reset values.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE to RUN: on the edge where start=1. That edge latches a, b and borrow_in into operand shift registers and the borrow flop, and clears bit index to 0.
- RUN, each edge: the bit cell takes {a_sh[0], b_sh[0], borrow_reg}. The difference bit shifts into the result shift register from the MSB side. borrow_reg takes the cell's borrow out. The operand registers shift right by one. The index increments.
- RUN, edge at index WIDTH-1 (the last bit):
  - diff takes the full result including the current bit.
  - borrow_out takes the cell's borrow out.
  - overflow takes borrow_reg (the borrow into the MSB) XOR the cell's borrow out.
  - done goes to 1 and the state returns to IDLE.
- Latency: start accepted at edge k; done=1 and results valid in the cycle after edge k+WIDTH. busy is high from after edge k through edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles minimum.
- done is high for exactly one cycle. It is deasserted on the next edge regardless of start.
- diff, borrow_out and overflow change only on the completion edge or on reset. They hold their last value through IDLE and through the next RUN, so partial results are never visible.
- start while busy=1 is ignored. Operands presented then are not captured.
- start=1 in the done cycle, where the state is already IDLE, is accepted. This gives back-to-back operation.
- start held high continuously restarts an operation every WIDTH+1 cycles.
- Bit cell equations:
  - d = a ^ b ^ bin
  - bout = (~a & b) | ((~a | b) & bin)
- Bit-counter width is $clog2(WIDTH). Terminal compare is against WIDTH-1.

Decomposition:
- Shared package sub_pkg holds:
  - state encodings ST_IDLE=1'b0 and ST_RUN=1'b1
  - the WIDTH legality check constants, MIN_WIDTH=2 and MAX_WIDTH=32
- Sub-module full_sub_cell: a purely combinational single-bit full subtractor (a, b, bin to d, bout), instantiated once.
- All sequencing lives in serial_sub_unit.

Test Plan:
- WIDTH=8, a=0x50, b=0x20, borrow_in=0, pulse start: busy for 8 cycles, then done with diff=0x30, borrow_out=0, overflow=0.
- a=0x20, b=0x50, borrow_in=0: diff=0xD0, borrow_out=1, overflow=0.
- a=0x80, b=0x01, borrow_in=0: diff=0x7F, borrow_out=0, overflow=1. Also a=0x7F, b=0xFF: diff=0x80, borrow_out=1, overflow=1.
- a=0x00, b=0x00, borrow_in=1: diff=0xFF, borrow_out=1, overflow=0. Then hold start high: the second operation begins in the done cycle and completes 9 cycles after the first.
- Start 0x50-0x20. At cycle 3 of RUN, drive start=1 with a=0xFF, b=0x00: it is ignored and the result is still 0x30. At cycle 4 of the next operation, assert rst_n=0: no done pulse, and all outputs are 0 on the following cycle.
- Exhaustive compare with WIDTH=4 over all a, b and borrow_in (512 cases) against the reference model {borrow_out, diff} = a - b - borrow_in, mod 32 (WIDTH+1 bits).

Source files
------------

// File: rtl/serial_sub_unit_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the legal operand width range.
package sub_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

endpackage : sub_pkg

// File: rtl/serial_sub_unit_full_sub_cell.sv
// Single-bit full subtractor: d = a - b - bin, with borrow out.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | ((~a | b) & bin);

endmodule : full_sub_cell

// File: rtl/serial_sub_unit.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full-subtractor cell.
// Results are published only on the completion edge, so partial sums never show.
module serial_sub_unit
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("serial_sub_unit: WIDTH out of range");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-2:0] res_q;
  logic             borrow_q;
  logic [CW-1:0]    idx_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic             cell_diff;
  logic             cell_bout;
  logic [WIDTH-1:0] res_full;

  full_sub_cell u_cell (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .bin (borrow_q),
    .d   (cell_diff),
    .bout(cell_bout)
  );

  // Result shifts in from the MSB side; after WIDTH bits it is aligned.
  assign res_full = {cell_diff, res_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_sh_q   <= a;
            b_sh_q   <= b;
            borrow_q <= borrow_in;
            idx_q    <= '0;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_q    <= res_full[WIDTH-1:1];
          borrow_q <= cell_bout;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          idx_q    <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            diff_q  <= res_full;
            bout_q  <= cell_bout;
            // borrow_q still holds the borrow into the MSB here
            ovf_q   <= borrow_q ^ cell_bout;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bout_q;
  assign overflow   = ovf_q;

endmodule : serial_sub_unit

// File: tb/tb_serial_sub_unit.sv
// Bench for serial_sub_unit: directed cases, random WIDTH=8 traffic and an
// exhaustive WIDTH=4 sweep, all against an arithmetic reference model.
module tb_serial_sub_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       s8, bi8, busy8, done8, bo8, ov8;
  logic [7:0] a8, b8, d8;
  logic       s4, bi4, busy4, done4, bo4, ov4;
  logic [3:0] a4, b4, d4;

  serial_sub_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .borrow_in(bi8),
    .busy(busy8), .done(done8), .diff(d8), .borrow_out(bo8), .overflow(ov8)
  );

  serial_sub_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .borrow_in(bi4),
    .busy(busy4), .done(done4), .diff(d4), .borrow_out(bo4), .overflow(ov4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // selects which instance the generic op task looks at
  bit sel4 = 1'b0;
  wire       cur_busy = sel4 ? busy4 : busy8;
  wire       cur_done = sel4 ? done4 : done8;
  wire [7:0] cur_diff = sel4 ? {4'h0, d4} : d8;
  wire       cur_bo   = sel4 ? bo4 : bo8;
  wire       cur_ov   = sel4 ? ov4 : ov8;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic, signed overflow by range test.
  function automatic void model(input int w, input int av, input int bv, input int bin,
                                output int ed, output int ebo, output int eov);
    int r, sa, sb, sr, half;
    half = 1 << (w - 1);
    r    = av - bv - bin;
    ed   = r & ((1 << w) - 1);
    ebo  = (r < 0) ? 1 : 0;
    sa   = (av >= half) ? av - (1 << w) : av;
    sb   = (bv >= half) ? bv - (1 << w) : bv;
    sr   = sa - sb - bin;
    eov  = (sr < -half || sr > half - 1) ? 1 : 0;
  endfunction

  task automatic drive(input bit s, input int av, input int bv, input int bin);
    if (sel4) begin
      s4 = s; a4 = av[3:0]; b4 = bv[3:0]; bi4 = bin[0];
    end else begin
      s8 = s; a8 = av[7:0]; b8 = bv[7:0]; bi8 = bin[0];
    end
  endtask

  // Runs one operation on the selected instance and checks everything.
  task automatic do_op(input int av, input int bv, input int bin);
    int w, cyc, ed, ebo, eov;
    bit busy_ok, hold_ok;
    logic [7:0] prev;
    w = sel4 ? 4 : 8;
    model(w, av, bv, bin, ed, ebo, eov);
    @(negedge clk);
    prev = cur_diff;
    drive(1'b1, av, bv, bin);
    @(negedge clk);
    drive(1'b0, 0, 0, 0);
    cyc = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (!cur_done && cyc < 40) begin
      if (!cur_busy) busy_ok = 1'b0;
      if (cur_diff !== prev) hold_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    $display("op w=%0d a=0x%0h b=0x%0h bin=%0d -> diff=0x%0h bo=%0d ov=%0d (exp 0x%0h %0d %0d) lat=%0d",
             w, av, bv, bin, cur_diff, cur_bo, cur_ov, ed, ebo, eov, cyc);
    check("latency", cyc, w);
    check("busy_run", busy_ok, 1);
    check("diff_hold", hold_ok, 1);
    check("busy_done", cur_busy, 0);
    check("diff", cur_diff, ed);
    check("borrow_out", cur_bo, ebo);
    check("overflow", cur_ov, eov);
    @(negedge clk);
    check("done_pulse", cur_done, 0);
  endtask

  task automatic wait_done8(output int cyc);
    cyc = 0;
    while (!done8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int t1, t2;
    bit saw_done;
    rst_n = 1'b0;
    s8 = 0; a8 = 0; b8 = 0; bi8 = 0;
    s4 = 0; a4 = 0; b4 = 0; bi4 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_diff", d8, 0);
    check("rst_bo", bo8, 0);
    check("rst_ov", ov8, 0);
    check("rst_busy4", busy4, 0);

    // directed cases
    sel4 = 1'b0;
    do_op(8'h50, 8'h20, 0);
    do_op(8'h20, 8'h50, 0);
    do_op(8'h80, 8'h01, 0);
    do_op(8'h7F, 8'hFF, 0);
    do_op(8'h00, 8'h00, 1);

    // start held high: second op accepted in the done cycle
    @(negedge clk);
    s8 = 1; a8 = 8'h00; b8 = 8'h00; bi8 = 1;
    @(negedge clk);
    wait_done8(t1);
    check("b2b_diff1", d8, 8'hFF);
    @(negedge clk);
    s8 = 0;
    check("b2b_busy", busy8, 1);
    wait_done8(t2);
    $display("back-to-back: second done %0d cycles after first", t2 + 1);
    check("b2b_gap", t2 + 1, 9);
    check("b2b_diff2", d8, 8'hFF);
    check("b2b_bo2", bo8, 1);
    @(negedge clk);

    // start during RUN is ignored
    @(negedge clk);
    s8 = 1; a8 = 8'h50; b8 = 8'h20; bi8 = 0;
    @(negedge clk);
    s8 = 0;
    repeat (2) @(negedge clk);
    s8 = 1; a8 = 8'hFF; b8 = 8'h00;
    @(negedge clk);
    s8 = 0;
    wait_done8(t1);
    $display("ignored start: diff=0x%0h", d8);
    check("ign_diff", d8, 8'h30);
    check("ign_done", done8, 1);
    @(negedge clk);
    check("ign_idle", busy8, 0);

    // reset mid-operation
    s8 = 1; a8 = 8'h20; b8 = 8'h50; bi8 = 0;
    @(negedge clk);
    s8 = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    $display("mid-op reset: busy=%0d diff=0x%0h bo=%0d ov=%0d", busy8, d8, bo8, ov8);
    check("mrst_busy", busy8, 0);
    check("mrst_diff", d8, 0);
    check("mrst_bo", bo8, 0);
    check("mrst_ov", ov8, 0);
    repeat (12) begin
      if (done8) saw_done = 1'b1;
      @(negedge clk);
    end
    check("mrst_nodone", saw_done, 0);

    // random WIDTH=8 traffic
    for (int i = 0; i < 150; i++)
      do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));

    // exhaustive WIDTH=4
    sel4 = 1'b1;
    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int bin = 0; bin < 2; bin++)
          do_op(av, bv, bin);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_sub_unit
